event_encoder4x2: RTL and testbench
===================================

# event_encoder4x2

Sequential 4-to-2 event encoder; it is the encoding counterpart of the 2-to-4 decoder. It detects rising edges on four request lines and queues them as pending events. It then emits each event as a 2-bit index over a valid/ready handshake, using fixed priority with line 0 highest. It sits between raw request/switch lines and any consumer that drives a 2-to-4 decoder or indexes by line number.

## Interface
- No parameters; widths are fixed at 4 request lines and a 2-bit code.
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  event-detect enable; 0 suppresses new events, queued events still drain
- x  input  4  request lines; x[i] rising edge = event i
- ready  input  1  consumer accepts y this cycle when valid=1
- clr_ovr  input  1  clears all overrun flags
- y  output  2  encoded index of the presented event
- valid  output  1  y holds an unaccepted event
- pending  output  4  queued events not yet loaded into y
- ovr  output  4  sticky per-line overrun flags

## Operation
- State registers: x_q[3:0], pending[3:0], y[1:0], valid, ovr[3:0]. All are 0 on reset, including every output.
- Edge detect: rise = {4{en}} & x & ~x_q. x_q <= x every cycle, regardless of en.
  - Releasing en while a line is high produces no event.
  - A line held high through reset produces one event on the first edge with rst=0, en=1, because x_q resets to 0.
- Output register is free when valid=0 or (valid & ready).
- Issue: when the output register is free and pending≠0, select the lowest set index i of the current pending value.
  - y <= i, valid <= 1, issue_mask = onehot(i).
  - When free and pending=0: valid <= 0, and y holds its last value.
  - When not free: issue_mask = 0, and y and valid hold.
- pending <= (pending & ~issue_mask) | rise. Issue uses the pre-edge pending value; rise bits are never issued in the same cycle they are detected.
- Overrun: ovr[i] <= 1 when rise[i] & pending[i] & ~issue_mask[i]. The second event is lost; pending[i] stays 1.
- A rise on the line currently in y (valid, not yet accepted) is not an overrun. It is queued in pending.
- A rise and an issue of the same line in the same cycle: pending[i] stays 1 as a new event, with no overrun.
- clr_ovr: ovr <= 0. A new overrun set in the same cycle wins, so that bit stays 1.
- Priority: fixed, index 0 highest. Starvation of higher indices under continuous line-0 traffic is accepted behaviour.

## Timing
- Event latency: x[i] rises before edge k → pending[i]=1 after edge k → y=i, valid=1 after edge k+1, provided the output register was free and no lower index was pending.
- Throughput: one event per cycle with ready held high.
- Back-to-back: on a cycle with valid & ready, the next event is loaded at the same edge, so there is no valid gap.
- valid and y are stable while valid=1 and ready=0.
- ready while valid=0 is ignored.
- Reset mid-operation: at the rst edge, all queued events, the presented y, and ovr are discarded; outputs are 0 after that edge.

## Test plan
- Reset: rst=1 for 2 cycles with x=4'b1111, en=1 → y=0, valid=0, pending=0, ovr=0. Then release rst → pending=4'b1111 after the first edge, and y=0, valid=1 one edge later.
- Single event: x 0000→0100 with ready=1 → pending=0100 after edge k; y=2'b10, valid=1 after k+1; valid=0 after k+2.
- Priority drain: x 0000→1011 at once, ready=1 → y sequence 0,1,3 on consecutive cycles with valid continuously 1, then valid=0; pending goes 1011→1010→1000→0000.
- Backpressure: ready=0 with y=0 presented; pulse x[0] again → pending[0]=1, ovr=0. Pulse x[0] a third time → ovr[0]=1. Raise ready → y=0 presented twice in total. Then clr_ovr=1 → ovr=0.
- Enable gating: en=0 while x 0000→1111 → pending=0 and valid=0. Then en=1 with x held high → still no events. Drop x and raise it again → events 0..3 are emitted.
- Reset mid-drain: pending=1110, valid=1; assert rst for one cycle → all outputs are 0 after that edge, and no residual event appears afterwards with x=0.

Source files
------------

// File: rtl/event_encoder4x2.sv
// event_encoder4x2: turns rising edges on four request lines into queued events
// and hands them out one at a time as a 2-bit index over valid/ready.
// Line 0 has the highest priority.
module event_encoder4x2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] x,
    input  logic       ready,
    input  logic       clr_ovr,
    output logic [1:0] y,
    output logic       valid,
    output logic [3:0] pending,
    output logic [3:0] ovr
);

    logic [3:0] x_q;
    logic [3:0] rise;
    logic       out_free;
    logic [3:0] issue_mask;
    logic [1:0] issue_idx;
    logic       issue_any;

    // Detect new events and choose which pending event moves into the output register
    always_comb begin
        rise       = {4{en}} & x & ~x_q;
        out_free   = ~valid | ready;
        issue_mask = 4'b0000;
        issue_idx  = 2'd0;
        issue_any  = 1'b0;
        if (out_free) begin
            if (pending[0]) begin
                issue_mask = 4'b0001;
                issue_idx  = 2'd0;
                issue_any  = 1'b1;
            end else if (pending[1]) begin
                issue_mask = 4'b0010;
                issue_idx  = 2'd1;
                issue_any  = 1'b1;
            end else if (pending[2]) begin
                issue_mask = 4'b0100;
                issue_idx  = 2'd2;
                issue_any  = 1'b1;
            end else if (pending[3]) begin
                issue_mask = 4'b1000;
                issue_idx  = 2'd3;
                issue_any  = 1'b1;
            end
        end
    end

    // Update the edge history, the pending queue, the output register and the overrun flags
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= 4'b0000;
            pending <= 4'b0000;
            y       <= 2'd0;
            valid   <= 1'b0;
            ovr     <= 4'b0000;
        end else begin
            x_q     <= x;
            pending <= (pending & ~issue_mask) | rise;
            if (out_free) begin
                if (issue_any) begin
                    y     <= issue_idx;
                    valid <= 1'b1;
                end else begin
                    valid <= 1'b0;
                end
            end
            ovr <= (clr_ovr ? 4'b0000 : ovr) | (rise & pending & ~issue_mask);
        end
    end

endmodule

// File: tb/tb_event_encoder4x2.sv
// tb_event_encoder4x2: random and directed stimulus checked against a
// set-based reference model through an expected-index scoreboard.
module tb_event_encoder4x2;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] x;
    logic       ready;
    logic       clr_ovr;
    logic [1:0] y;
    logic       valid;
    logic [3:0] pending;
    logic [3:0] ovr;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit m_prev [4];
    bit m_pend [4];
    bit m_ovr  [4];
    int m_cur = -1;
    bit m_last_rst = 0;
    int exp_q[$];

    event_encoder4x2 dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .x      (x),
        .ready  (ready),
        .clr_ovr(clr_ovr),
        .y      (y),
        .valid  (valid),
        .pending(pending),
        .ovr    (ovr)
    );

    // free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int packBits(input bit b [4]);
        int v;
        v = 0;
        for (int i = 0; i < 4; i++) if (b[i]) v = v + (1 << i);
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] xv, input logic env, input logic rdy,
                                 input logic clr, input logic rs);
        @(negedge clk);
        x       = xv;
        en      = env;
        ready   = rdy;
        clr_ovr = clr;
        rst     = rs;
    endtask

    // reference model: events are a set of pending line numbers plus the one presented
    always @(posedge clk) begin
        int  issued;
        bit  out_free;
        bit  r;
        m_last_rst = rst;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_prev[i] = 0;
                m_pend[i] = 0;
                m_ovr[i]  = 0;
            end
            m_cur = -1;
            exp_q.delete();
        end else begin
            out_free = (m_cur < 0) || (ready == 1'b1);
            issued   = -1;
            if (out_free) begin
                for (int i = 0; i < 4; i++) if (m_pend[i] && issued < 0) issued = i;
            end
            if (clr_ovr) begin
                for (int i = 0; i < 4; i++) m_ovr[i] = 0;
            end
            for (int i = 0; i < 4; i++) begin
                r = en && x[i] && !m_prev[i];
                if (r && m_pend[i] && issued != i) m_ovr[i] = 1;
                m_pend[i] = (m_pend[i] && issued != i) || r;
                m_prev[i] = x[i];
            end
            if (out_free) begin
                m_cur = issued;
                if (issued >= 0) exp_q.push_back(issued);
            end
        end
    end

    // monitor: compare state every cycle and pop the scoreboard on each handshake
    initial begin
        int e;
        forever begin
            @(negedge clk);
            #1;
            checkOutput("valid", int'(valid), (m_cur >= 0) ? 1 : 0);
            checkOutput("pending", int'(pending), packBits(m_pend));
            checkOutput("ovr", int'(ovr), packBits(m_ovr));
            if (m_last_rst) checkOutput("y_after_reset", int'(y), 0);
            if (valid === 1'b1 && ready === 1'b1 && rst === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL y_unexpected: got y=%0d expected no event at %0t", y, $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("y", int'(y), e);
                end
            end
        end
    end

    // stimulus: directed scenarios then randomized traffic
    initial begin
        x = 4'b0000; en = 1'b1; ready = 1'b0; clr_ovr = 1'b0; rst = 1'b1;

        // reset with all lines held high, then release
        applyStimulus(4'b1111, 1, 1, 0, 1);
        applyStimulus(4'b1111, 1, 1, 0, 1);
        repeat (6) applyStimulus(4'b1111, 1, 1, 0, 0);
        repeat (2) applyStimulus(4'b0000, 1, 1, 0, 0);

        // single event
        repeat (4) applyStimulus(4'b0100, 1, 1, 0, 0);
        repeat (2) applyStimulus(4'b0000, 1, 1, 0, 0);

        // priority drain
        repeat (5) applyStimulus(4'b1011, 1, 1, 0, 0);
        repeat (2) applyStimulus(4'b0000, 1, 1, 0, 0);

        // backpressure and overrun
        applyStimulus(4'b0001, 1, 0, 0, 0);
        applyStimulus(4'b0000, 1, 0, 0, 0);
        applyStimulus(4'b0000, 1, 0, 0, 0);
        applyStimulus(4'b0001, 1, 0, 0, 0);
        applyStimulus(4'b0000, 1, 0, 0, 0);
        applyStimulus(4'b0001, 1, 0, 0, 0);
        applyStimulus(4'b0000, 1, 0, 0, 0);
        repeat (3) applyStimulus(4'b0000, 1, 1, 0, 0);
        applyStimulus(4'b0000, 1, 1, 1, 0);
        applyStimulus(4'b0000, 1, 1, 0, 0);

        // enable gating
        repeat (3) applyStimulus(4'b1111, 0, 1, 0, 0);
        repeat (3) applyStimulus(4'b1111, 1, 1, 0, 0);
        applyStimulus(4'b0000, 1, 1, 0, 0);
        repeat (6) applyStimulus(4'b1111, 1, 1, 0, 0);
        applyStimulus(4'b0000, 1, 1, 0, 0);

        // reset in the middle of a drain
        applyStimulus(4'b1111, 1, 0, 0, 0);
        applyStimulus(4'b1111, 1, 0, 0, 0);
        applyStimulus(4'b1111, 1, 0, 0, 0);
        applyStimulus(4'b0000, 1, 0, 0, 1);
        repeat (4) applyStimulus(4'b0000, 1, 1, 0, 0);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            logic [3:0] xr;
            xr = x;
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) xr[i] = ~xr[i];
            applyStimulus(xr, ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0));
        end

        // drain everything
        repeat (8) applyStimulus(4'b0000, 1, 1, 0, 0);
        @(negedge clk);
        #2;
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
